// File: rtl/mock_cu_multi.sv
// Mock multi-device control unit on the bus-and-tag channel: selection, command decode,
// READ/WRITE/SENSE transfers, STOP and status. Optional macro: MOCK_CU_PARITY_CHECK_EN.
module mock_cu_multi #(
    parameter logic [7:0] BASE_ADDRESS = 8'h40,
    parameter int         NUM_DEVICES  = 4,
    parameter int         SENSE_BYTES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             bus_out,
    input  logic                   bus_out_parity,
    output logic [7:0]             bus_in,
    output logic                   bus_in_parity,
    input  logic                   operational_out,
    input  logic                   address_out,
    input  logic                   command_out,
    input  logic                   service_out,
    input  logic                   suppress_out,
    input  logic                   selection_x,
    output logic                   selection_y,
    output logic                   operational_in,
    output logic                   address_in,
    output logic                   status_in,
    output logic                   service_in,
    output logic                   request_in,
    input  logic [NUM_DEVICES-1:0] mock_busy,
    input  logic                   mock_short_busy,
    input  logic [15:0]            mock_limit,
    output logic [3:0]             device,
    output logic [7:0]             command,
    output logic [15:0]            count,
    output logic [7:0]             checksum
);
    localparam int          DW          = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
    localparam int unsigned DEPTH       = 1 << DW;
    localparam logic [8:0]  NUM9        = 9'(NUM_DEVICES);
    localparam logic [15:0] SENSE_LIMIT = 16'(SENSE_BYTES);
    localparam logic [7:0]  CMD_TEST_IO = 8'h00, CMD_WRITE = 8'h01, CMD_READ = 8'h02,
                            CMD_NOP = 8'h03, CMD_SENSE = 8'h04;

    typedef enum logic [3:0] {
        IDLE, SEL, ADDR, CMDDROP, DECODE, INIT_STATUS, INIT_DROP,
        DIN, DIN_DROP, DOUT, DOUT_DROP, STOP_WAIT, END_STATUS, SHORT_BUSY
    } state_t;

    state_t      state, state_n;
    logic [7:0]  sense [DEPTH];
    logic [7:0]  status, status_n, command_n, checksum_n, bus_in_n, din_byte;
    logic [3:0]  device_n;
    logic [15:0] count_n, limit;
    logic        data_err, data_err_n, cmd_err, cmd_err_n, stopped, stopped_n;
    logic        selection_y_n, set5, set7, clr_sense, par_err;
    logic [8:0]  offset9;
    logic        in_range;
    logic [DEPTH-1:0] busy_ext;
    logic [DW-1:0]    dev_idx;

`ifdef MOCK_CU_PARITY_CHECK_EN
    assign par_err = (bus_out_parity != ~^bus_out);
    logic unused_inputs;
    assign unused_inputs = suppress_out;
`else
    assign par_err = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{suppress_out, bus_out_parity};
`endif

    assign request_in    = 1'b0;
    assign bus_in_parity = ~^bus_in;
    assign dev_idx       = device[DW-1:0];
    assign offset9       = {1'b0, bus_out} - {1'b0, BASE_ADDRESS};
    assign in_range      = !offset9[8] && (offset9 < NUM9);
    assign limit         = (command == CMD_SENSE) ? SENSE_LIMIT : mock_limit;

    always_comb begin
        busy_ext = '0;
        busy_ext[NUM_DEVICES-1:0] = mock_busy;
    end

    always_comb begin
        state_n       = state;
        device_n      = device;
        command_n     = command;
        count_n       = count;
        checksum_n    = checksum;
        status_n      = status;
        data_err_n    = data_err;
        cmd_err_n     = cmd_err;
        stopped_n     = stopped;
        set5          = 1'b0;
        set7          = 1'b0;
        clr_sense     = 1'b0;
        selection_y_n = 1'b0;
        case (state)
            IDLE: if (address_out && selection_x && in_range) begin
                device_n = offset9[3:0];
                state_n  = mock_short_busy ? SHORT_BUSY : SEL;
            end
            SEL: begin
                count_n    = '0;
                checksum_n = '0;
                data_err_n = 1'b0;
                cmd_err_n  = 1'b0;
                stopped_n  = 1'b0;
                if (!address_out) state_n = ADDR;
            end
            ADDR: if (command_out) begin
                command_n = bus_out;
                cmd_err_n = par_err;
                set5      = par_err;
                state_n   = CMDDROP;
            end
            CMDDROP: if (!command_out) state_n = DECODE;
            DECODE: begin
                state_n = INIT_STATUS;
                if (busy_ext[dev_idx])          status_n = 8'h10;
                else if (cmd_err)               status_n = 8'h0E;
                else if (command == CMD_NOP)    status_n = 8'h0C;
                else if (command inside {CMD_TEST_IO, CMD_WRITE, CMD_READ, CMD_SENSE})
                                                status_n = 8'h00;
                else begin
                    status_n = 8'h0E;
                    set7     = 1'b1;
                end
            end
            INIT_STATUS: if (service_out) state_n = INIT_DROP;
            INIT_DROP: if (!service_out) begin
                if (status[4] || (status[3:2] == 2'b11) || command == CMD_TEST_IO)
                    state_n = IDLE;
                else if ((command == CMD_READ || command == CMD_WRITE) && mock_limit == '0)
                    state_n = END_STATUS;
                else if (command == CMD_READ || command == CMD_SENSE)
                    state_n = DIN;
                else if (command == CMD_WRITE)
                    state_n = DOUT;
                else
                    state_n = IDLE;
            end
            DIN: if (command_out) begin
                stopped_n = 1'b1;
                state_n   = STOP_WAIT;
            end else if (service_out) begin
                count_n = count + 16'd1;
                state_n = DIN_DROP;
            end
            DOUT: if (command_out) begin
                stopped_n = 1'b1;
                state_n   = STOP_WAIT;
            end else if (service_out) begin
                checksum_n = checksum ^ bus_out;
                count_n    = count + 16'd1;
                set5       = par_err;
                if (par_err) data_err_n = 1'b1;
                state_n    = DOUT_DROP;
            end
            DIN_DROP:   if (!service_out) state_n = (count == limit) ? END_STATUS : DIN;
            DOUT_DROP:  if (!service_out) state_n = (count == limit) ? END_STATUS : DOUT;
            STOP_WAIT:  if (!command_out) state_n = END_STATUS;
            END_STATUS: if (service_out) begin
                clr_sense = (command == CMD_SENSE) && !stopped;
                state_n   = IDLE;
            end
            SHORT_BUSY: if (!selection_x) state_n = IDLE;
            default:    state_n = IDLE;
        endcase

        // An abort discards everything this cycle would have changed except the return to IDLE.
        if (!operational_out) begin
            state_n    = IDLE;
            device_n   = device;
            command_n  = command;
            count_n    = count;
            checksum_n = checksum;
            status_n   = status;
            data_err_n = data_err;
            cmd_err_n  = cmd_err;
            stopped_n  = stopped;
            set5       = 1'b0;
            set7       = 1'b0;
            clr_sense  = 1'b0;
        end
        if (state_n == IDLE) selection_y_n = selection_x;
    end

    always_comb begin
        if (command == CMD_SENSE)
            din_byte = (count_n == '0) ? sense[dev_idx] : 8'h00;
        else
            din_byte = count_n[7:0] + 8'd1 + {device, 4'h0};
        bus_in_n = '0;
        case (state_n)
            ADDR:        bus_in_n = BASE_ADDRESS + {4'h0, device_n};
            INIT_STATUS: bus_in_n = status_n;
            DIN:         bus_in_n = din_byte;
            END_STATUS:  bus_in_n = data_err_n ? 8'h0E : 8'h0C;
            SHORT_BUSY:  bus_in_n = 8'h10;
            default:     bus_in_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus_in         <= '0;
            selection_y    <= selection_x;
            operational_in <= 1'b0;
            address_in     <= 1'b0;
            status_in      <= 1'b0;
            service_in     <= 1'b0;
            device         <= '0;
            command        <= '0;
            count          <= '0;
            checksum       <= '0;
            status         <= '0;
            data_err       <= 1'b0;
            cmd_err        <= 1'b0;
            stopped        <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) sense[i] <= '0;
        end else begin
            state          <= state_n;
            bus_in         <= bus_in_n;
            selection_y    <= selection_y_n;
            operational_in <= !(state_n inside {IDLE, SHORT_BUSY});
            address_in     <= (state_n == ADDR);
            status_in      <= (state_n inside {INIT_STATUS, END_STATUS, SHORT_BUSY});
            service_in     <= (state_n inside {DIN, DOUT});
            device         <= device_n;
            command        <= command_n;
            count          <= count_n;
            checksum       <= checksum_n;
            status         <= status_n;
            data_err       <= data_err_n;
            cmd_err        <= cmd_err_n;
            stopped        <= stopped_n;
            if (clr_sense)
                sense[dev_idx] <= '0;
            else if (set5 || set7)
                sense[dev_idx] <= sense[dev_idx] | {set7, 1'b0, set5, 5'b0};
        end
    end
endmodule

// File: tb/tb_mock_cu_multi.sv
// Directed bench for mock_cu_multi: channel-side tag handshakes with hand-computed expectations.
module tb_mock_cu_multi;
    logic        clk = 1'b0;
    logic        reset, bus_out_parity, bus_in_parity;
    logic [7:0]  bus_out, bus_in;
    logic        operational_out, address_out, command_out, service_out, suppress_out;
    logic        selection_x, selection_y, operational_in, address_in, status_in, service_in, request_in;
    logic [3:0]  mock_busy;
    logic        mock_short_busy;
    logic [15:0] mock_limit;
    logic [3:0]  device;
    logic [7:0]  command, checksum;
    logic [15:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    mock_cu_multi #(.BASE_ADDRESS(8'h40), .NUM_DEVICES(4), .SENSE_BYTES(2)) dut (
        .clk(clk), .reset(reset), .bus_out(bus_out), .bus_out_parity(bus_out_parity),
        .bus_in(bus_in), .bus_in_parity(bus_in_parity), .operational_out(operational_out),
        .address_out(address_out), .command_out(command_out), .service_out(service_out),
        .suppress_out(suppress_out), .selection_x(selection_x), .selection_y(selection_y),
        .operational_in(operational_in), .address_in(address_in), .status_in(status_in),
        .service_in(service_in), .request_in(request_in), .mock_busy(mock_busy),
        .mock_short_busy(mock_short_busy), .mock_limit(mock_limit), .device(device),
        .command(command), .count(count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tag_of(input int which);
        case (which)
            0:       return address_in;
            1:       return status_in;
            default: return service_in;
        endcase
    endfunction

    task automatic wait_tag(input int which, input string tag);
        int n = 0;
        while (tag_of(which) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, tag_of(which)}, 32'd1);
    endtask

    task automatic start_cmd(input logic [7:0] addr, input logic [7:0] cmd,
                             input logic [7:0] exp_status, input string tag);
        bus_out = addr; address_out = 1'b1; selection_x = 1'b1;
        tick();
        address_out = 1'b0; selection_x = 1'b0;
        wait_tag(0, {tag, "_addr_in"});
        chk({tag, "_addr"}, bus_in, addr);
        bus_out = cmd; command_out = 1'b1;
        tick();
        command_out = 1'b0;
        wait_tag(1, {tag, "_init_tag"});
        chk({tag, "_init_status"}, bus_in, exp_status);
        service_out = 1'b1;
        tick();
        service_out = 1'b0;
        tick();
    endtask

    task automatic read_byte(input logic [7:0] exp, input string tag);
        wait_tag(2, {tag, "_svc"});
        chk(tag, bus_in, exp);
        chk({tag, "_par"}, bus_in_parity, ~^exp);
        service_out = 1'b1;
        tick();
        service_out = 1'b0;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] data, input string tag);
        wait_tag(2, {tag, "_svc"});
        bus_out = data; bus_out_parity = ~^data; service_out = 1'b1;
        tick();
        service_out = 1'b0;
        tick();
    endtask

    task automatic end_status(input logic [7:0] exp, input string tag);
        wait_tag(1, {tag, "_tag"});
        chk(tag, bus_in, exp);
        service_out = 1'b1;
        tick();
        service_out = 1'b0;
        chk({tag, "_idle"}, operational_in, 1'b0);
    endtask

    initial begin
        reset = 1'b1; operational_out = 1'b1; bus_out = '0; bus_out_parity = 1'b1;
        address_out = 1'b0; command_out = 1'b0; service_out = 1'b0; suppress_out = 1'b0;
        selection_x = 1'b1; mock_busy = '0; mock_short_busy = 1'b0; mock_limit = 16'd3;
        tick(); tick();
        chk("rst_tags", {operational_in, address_in, status_in, service_in, request_in}, 5'b0);
        chk("rst_sel_y", selection_y, 1'b1);
        chk("rst_bus_in", {bus_in, bus_in_parity}, {8'h00, 1'b1});
        chk("rst_regs", {device, command, count, checksum}, 36'h0);
        reset = 1'b0; selection_x = 1'b0;
        tick();

        start_cmd(8'h41, 8'h03, 8'h0C, "nop");
        chk("nop_idle", operational_in, 1'b0);
        chk("nop_dev_cmd", {device, command}, {4'd1, 8'h03});

        start_cmd(8'h40, 8'h02, 8'h00, "rd0");
        read_byte(8'h01, "rd0_b0"); read_byte(8'h02, "rd0_b1"); read_byte(8'h03, "rd0_b2");
        end_status(8'h0C, "rd0_end");
        chk("rd0_count", count, 16'd3);

        start_cmd(8'h42, 8'h02, 8'h00, "rd2");
        read_byte(8'h21, "rd2_b0"); read_byte(8'h22, "rd2_b1"); read_byte(8'h23, "rd2_b2");
        end_status(8'h0C, "rd2_end");

        mock_limit = 16'd4;
        start_cmd(8'h40, 8'h01, 8'h00, "wr0");
        write_byte(8'hA5, "wr0_b0"); write_byte(8'h5A, "wr0_b1");
        write_byte(8'hFF, "wr0_b2"); write_byte(8'h00, "wr0_b3");
        end_status(8'h0C, "wr0_end");
        chk("wr0_sum_cnt", {checksum, count}, {8'h00, 16'd4});
        start_cmd(8'h43, 8'h01, 8'h00, "wr1");
        write_byte(8'h12, "wr1_b0"); write_byte(8'h34, "wr1_b1");
        write_byte(8'h56, "wr1_b2"); write_byte(8'h78, "wr1_b3");
        end_status(8'h0C, "wr1_end");
        chk("wr1_sum_cnt", {checksum, count}, {8'h08, 16'd4});

        start_cmd(8'h43, 8'h77, 8'h0E, "bad");
        chk("bad_idle", operational_in, 1'b0);
        start_cmd(8'h43, 8'h04, 8'h00, "sns1");
        read_byte(8'h80, "sns1_b0"); read_byte(8'h00, "sns1_b1");
        end_status(8'h0C, "sns1_end");
        start_cmd(8'h43, 8'h04, 8'h00, "sns2");
        read_byte(8'h00, "sns2_b0"); read_byte(8'h00, "sns2_b1");
        end_status(8'h0C, "sns2_end");

        start_cmd(8'h40, 8'h00, 8'h00, "tio");
        chk("tio_idle", operational_in, 1'b0);

        mock_busy = 4'b0100;
        start_cmd(8'h42, 8'h02, 8'h10, "busy");
        chk("busy_idle", operational_in, 1'b0);
        mock_busy = '0;

        mock_short_busy = 1'b1;
        bus_out = 8'h41; address_out = 1'b1; selection_x = 1'b1;
        tick();
        address_out = 1'b0;
        tick();
        chk("sbusy_tags", {status_in, operational_in, selection_y}, 3'b100);
        chk("sbusy_bus", bus_in, 8'h10);
        selection_x = 1'b0;
        tick();
        chk("sbusy_idle", status_in, 1'b0);
        mock_short_busy = 1'b0;

        bus_out = 8'h50; address_out = 1'b1; selection_x = 1'b1;
        tick();
        chk("pass_thru", {selection_y, operational_in}, 2'b10);
        address_out = 1'b0; selection_x = 1'b0;
        tick();
        chk("pass_thru_drop", selection_y, 1'b0);

        mock_limit = 16'd10;
        start_cmd(8'h40, 8'h02, 8'h00, "stop");
        read_byte(8'h01, "stop_b0"); read_byte(8'h02, "stop_b1");
        wait_tag(2, "stop_svc");
        command_out = 1'b1;
        tick();
        command_out = 1'b0;
        end_status(8'h0C, "stop_end");
        chk("stop_count", count, 16'd2);

        mock_limit = 16'd0;
        start_cmd(8'h41, 8'h02, 8'h00, "zero");
        end_status(8'h0C, "zero_end");
        chk("zero_count", count, 16'd0);

        mock_limit = 16'd5;
        start_cmd(8'h40, 8'h02, 8'h00, "abort");
        read_byte(8'h01, "abort_b0");
        operational_out = 1'b0;
        tick();
        chk("abort_tags", {operational_in, status_in, service_in, address_in}, 4'b0);
        chk("abort_bus", bus_in, 8'h00);
        operational_out = 1'b1;
        tick();

        start_cmd(8'h41, 8'h99, 8'h0E, "bad1");
        start_cmd(8'h41, 8'h04, 8'h00, "snsab");
        wait_tag(2, "snsab_svc");
        chk("snsab_b0", bus_in, 8'h80);
        operational_out = 1'b0;
        tick();
        operational_out = 1'b1;
        tick();
        start_cmd(8'h41, 8'h04, 8'h00, "snsr");
        read_byte(8'h80, "snsr_b0"); read_byte(8'h00, "snsr_b1");
        end_status(8'h0C, "snsr_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
